// File: rtl/csel_sub_pkg.sv
// csel_sub_pkg: shared slice width and FSM state encoding for the carry-select subtractor
package csel_sub_pkg;
    localparam int SLICE_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;
endpackage

// File: rtl/csel_sub_seq_if.sv
// csel_sub_seq_if: operand/result handshake bundle for csel_sub_seq
//   in_valid/in_ready + a, b, bin : operand channel (master -> slave)
//   out_valid/out_ready + diff, bout, ovf : result channel (slave -> master)
interface csel_sub_seq_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    modport master (output in_valid, a, b, bin, out_ready,
                    input  in_ready, out_valid, diff, bout, ovf);
    modport slave  (input  in_valid, a, b, bin, out_ready,
                    output in_ready, out_valid, diff, bout, ovf);
endinterface

// File: rtl/csel_sub_slice.sv
// csel_sub_slice: combinational 4-bit subtract slice with both borrow-in variants precomputed
//   a, b : slice operands   bsel : running borrow selecting the variant
//   d    : selected difference   bo : selected borrow out
module csel_sub_slice
    import csel_sub_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bsel,
    output logic [SLICE_W-1:0] d,
    output logic               bo
);
    logic [SLICE_W:0] d0, d1;
    // The extra top bit of each extended difference is that variant's borrow.
    assign d0 = {1'b0, a} - {1'b0, b};
    assign d1 = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, 1'b1};
    assign d  = bsel ? d1[SLICE_W-1:0] : d0[SLICE_W-1:0];
    assign bo = bsel ? d1[SLICE_W] : d0[SLICE_W];
endmodule

// File: rtl/csel_sub_seq.sv
// csel_sub_seq: multi-cycle carry-select subtractor, one 4-bit slice per clock
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : slave side of csel_sub_seq_if (operands in, diff/bout/ovf out)
module csel_sub_seq
    import csel_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    csel_sub_seq_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    if (WIDTH < SLICE_W || WIDTH % SLICE_W != 0) begin : g_bad_width
        $error("csel_sub_seq: WIDTH must be a positive multiple of 4");
    end

    logic [1:0]         state;
    logic [IW-1:0]      idx;
    logic [WIDTH-1:0]   a_r, b_r, diff_r;
    logic               brw, bout_r, ovf_r, vld;
    logic [SLICE_W-1:0] sd;
    logic               sbo, last;

    csel_sub_slice u_slice (
        .a    (a_r[idx*SLICE_W +: SLICE_W]),
        .b    (b_r[idx*SLICE_W +: SLICE_W]),
        .bsel (brw),
        .d    (sd),
        .bo   (sbo)
    );

    assign last          = (idx == IW'(NSLICE - 1));
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = vld;
    assign bus.diff      = diff_r;
    assign bus.bout      = bout_r;
    assign bus.ovf       = ovf_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            brw    <= 1'b0;
            diff_r <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
            vld    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    a_r   <= bus.a;
                    b_r   <= bus.b;
                    brw   <= bus.bin;
                    idx   <= '0;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    diff_r[idx*SLICE_W +: SLICE_W] <= sd;
                    brw <= sbo;
                    idx <= idx + 1'b1;
                    if (last) begin
                        bout_r <= sbo;
                        // sd[3] is the final result MSB, written this same edge
                        ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sd[SLICE_W-1] != a_r[WIDTH-1]);
                        vld    <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: if (bus.out_ready) begin
                    vld   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csel_sub_seq.sv
// tb_csel_sub_seq: directed vector bench for csel_sub_seq at WIDTH=16
module tb_csel_sub_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    csel_sub_seq_if #(.WIDTH(16)) bus ();

    csel_sub_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic bi);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = x;
        bus.b = y;
        bus.bin = bi;
        chk("in_ready_before_accept", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Called at the negedge just after the accept edge; returns with out_valid seen.
    task automatic wait_done();
        int n = 0;
        logic busy_ready = 1'b0;
        while (!bus.out_valid && n < 20) begin
            if (bus.in_ready) busy_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("latency", n, 4);
        chk("in_ready_busy", busy_ready, 0);
    endtask

    task automatic drain();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("out_valid_after_take", bus.out_valid, 0);
        chk("in_ready_after_take", bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        bus.out_ready = 1'b0;
        tv[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        tv[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tv[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        tv[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        tv[4] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tv[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tv[6] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};
        tv[7] = '{16'h0F0F, 16'h0F10, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_diff", bus.diff, 0);
        chk("reset_bout", bus.bout, 0);
        chk("reset_ovf", bus.ovf, 0);

        for (int i = 0; i < 8; i++) begin
            start_op(tv[i].a, tv[i].b, tv[i].bi);
            wait_done();
            chk($sformatf("diff[%0d]", i), bus.diff, tv[i].d);
            chk($sformatf("bout[%0d]", i), bus.bout, tv[i].bo);
            chk($sformatf("ovf[%0d]", i), bus.ovf, tv[i].ov);
            drain();
        end

        // Backpressure: result held, new operands ignored while DONE
        start_op(16'h1234, 16'h0234, 1'b0);
        wait_done();
        bus.in_valid = 1'b1;
        bus.a = 16'h0003;
        bus.b = 16'h0001;
        bus.bin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_diff", bus.diff, 16'h1000);
            chk("bp_bout", bus.bout, 0);
            chk("bp_ovf", bus.ovf, 0);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_idle_in_ready", bus.in_ready, 1);
        chk("bp_idle_out_valid", bus.out_valid, 0);
        chk("bp_idle_diff_kept", bus.diff, 16'h1000);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done();
        chk("bp_new_diff", bus.diff, 16'h0002);
        chk("bp_new_bout", bus.bout, 0);
        drain();

        // Reset after slice 1 of 0xFFFF - 0x0001
        start_op(16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_bout", bus.bout, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rst_no_stray_output", bus.out_valid, 0);
        start_op(16'h0003, 16'h0001, 1'b0);
        wait_done();
        chk("post_rst_diff", bus.diff, 16'h0002);
        chk("post_rst_bout", bus.bout, 0);
        chk("post_rst_ovf", bus.ovf, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/csel_sub_seq.md
Name: csel_sub_seq

Overview:
Multi-cycle carry-select subtractor, the inverse operation to the team's 4-bit carry-select adder. It computes a - b - bin over WIDTH bits, one 4-bit slice per clock. Each slice precomputes both borrow-in variants and selects one with the running borrow. It sits behind a valid/ready handshake on both sides, so it can be dropped into the datapath wherever the combinational adder's counterpart is needed without a long ripple path.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, number of 4-bit slices; derived, never overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
- bout  output  1  unsigned borrow out: 1 iff a < b + bin
- ovf  output  1  signed overflow

Behaviour:
- Reset, sampled at a clk edge with rst_n=0:
  - state becomes IDLE; slice index, operand and borrow registers, diff, bout, ovf and out_valid all become 0.
  - Any in-flight operation is discarded with no output.
- States: IDLE, RUN, DONE.
- in_ready = (state == IDLE), decoded combinationally. It is high in the first cycle after reset and low in RUN and DONE. There is no input/output bypass.
- IDLE:
  - On in_valid && in_ready at edge T: latch a, b and bin into the running-borrow register; set idx=0; go to RUN.
  - in_valid without acceptance has no effect.
- RUN, one slice per edge:
  - The slice computes d0 = a[k] - b[k] and d1 = a[k] - b[k] - 1, each with its own 4-bit difference and borrow.
  - The running borrow selects one variant; diff[k] gets the selected difference and the borrow register gets the selected borrow. idx increments.
  - At the edge processing slice NSLICE-1: bout = final borrow, ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), out_valid=1, go to DONE.
- Latency: accepted at edge T, out_valid goes high after edge T+NSLICE (4 cycles at WIDTH=16).
- DONE:
  - diff, bout, ovf and out_valid are held stable until out_valid && out_ready.
  - On that edge: out_valid=0, go to IDLE. diff, bout and ovf retain their values until the next completion.
  - The next accept can occur at the following edge.
- diff is written slice by slice during RUN. It is only meaningful while out_valid=1.
- Arithmetic is unsigned modulo 2^WIDTH. bout and ovf are independent flags; both may be set together.
- WIDTH=4 degenerates to a single RUN cycle. Same protocol applies.
- rst_n low in any state has priority over the handshake and slice update in the same cycle.

Decomposition:
- Package csel_sub_pkg:
  - constant SLICE_W = 4
  - state enum sub_state_t {IDLE, RUN, DONE}
- Sub-module csel_sub_slice:
  - Purely combinational.
  - Inputs: 4-bit a, 4-bit b, borrow-select.
  - Computes both borrow variants and outputs the selected 4-bit difference and borrow.
  - Instantiated once; the slice operands are muxed by idx.

Test Plan (WIDTH=16):
- 0x1234 - 0x0234, bin=0 -> diff=0x1000, bout=0, ovf=0; out_valid high exactly 4 edges after accept; in_ready low throughout.
- 0x0000 - 0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0; confirms the borrow propagates across every slice boundary.
- 0x8000 - 0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. Also 0x7FFF - 0xFFFF -> diff=0x8000, bout=1, ovf=1.
- 0x0005 - 0x0005, bin=1 -> diff=0xFFFF, bout=1, ovf=0; confirms bin seeds the slice-0 select.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands.
  - diff, bout, ovf and out_valid stay stable; in_ready stays 0; the new operands are not captured.
  - Raise out_ready -> IDLE next edge; the new operands are accepted on the following edge.
- Reset mid-operation: assert rst_n=0 for one edge after slice 1 of 0xFFFF - 0x0001.
  - Next cycle: out_valid=0, diff=0, bout=0, ovf=0, in_ready=1.
  - A subsequent 0x0003 - 0x0001 completes normally with diff=0x0002.
